// File: rtl/wb_stage_regfile.sv
// Y86 writeback stage: W pipeline register, program register file with two
// combinational decode read ports, and the sticky architectural halt status.
module wb_stage_regfile #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned NREG   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              W_stall_i,
    input  logic              W_bubble_i,
    input  logic [3:0]        M_stat_i,
    input  logic [3:0]        M_icode_i,
    input  logic [3:0]        M_dstE_i,
    input  logic [WORD_W-1:0] M_valE_i,
    input  logic [3:0]        M_dstM_i,
    input  logic [WORD_W-1:0] m_valM_i,
    input  logic [3:0]        d_srcA_i,
    input  logic [3:0]        d_srcB_i,
    output logic [3:0]        W_stat_o,
    output logic [3:0]        W_icode_o,
    output logic [3:0]        W_dstE_o,
    output logic [WORD_W-1:0] W_valE_o,
    output logic [3:0]        W_dstM_o,
    output logic [WORD_W-1:0] W_valM_o,
    output logic [WORD_W-1:0] d_rvalA_o,
    output logic [WORD_W-1:0] d_rvalB_o,
    output logic [3:0]        stat_o,
    output logic              halted_o
);

    localparam int unsigned IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [3:0] SBUB  = 4'd0;
    localparam logic [3:0] SAOK  = 4'd1;
    localparam logic [3:0] SHLT  = 4'd2;
    localparam logic [3:0] SADR  = 4'd3;
    localparam logic [3:0] SINS  = 4'd4;
    localparam logic [3:0] INOP  = 4'd1;
    localparam logic [3:0] RNONE = 4'hF;

    logic [3:0]        w_stat_q,  w_stat_d;
    logic [3:0]        w_icode_q, w_icode_d;
    logic [3:0]        w_dste_q,  w_dste_d;
    logic [WORD_W-1:0] w_vale_q,  w_vale_d;
    logic [3:0]        w_dstm_q,  w_dstm_d;
    logic [WORD_W-1:0] w_valm_q,  w_valm_d;
    logic              halted_q,  halted_d;
    logic [3:0]        hstat_q,   hstat_d;
    logic [3:0]        stat_q,    stat_d;
    logic [WORD_W-1:0] regs_q [NREG];
    logic [WORD_W-1:0] regs_d [NREG];
    logic              wr_en;

    // W pipeline register next state: bubble beats stall
    always_comb begin
        w_stat_d  = w_stat_q;
        w_icode_d = w_icode_q;
        w_dste_d  = w_dste_q;
        w_vale_d  = w_vale_q;
        w_dstm_d  = w_dstm_q;
        w_valm_d  = w_valm_q;
        if (W_bubble_i) begin
            w_stat_d  = SBUB;
            w_icode_d = INOP;
            w_dste_d  = RNONE;
            w_vale_d  = '0;
            w_dstm_d  = RNONE;
            w_valm_d  = '0;
        end else if (!W_stall_i) begin
            w_stat_d  = M_stat_i;
            w_icode_d = M_icode_i;
            w_dste_d  = M_dstE_i;
            w_vale_d  = M_valE_i;
            w_dstm_d  = M_dstM_i;
            w_valm_d  = m_valM_i;
        end
    end

    // Retire the current W contents; the M write is applied last so it wins on dstE == dstM
    always_comb begin
        regs_d   = regs_q;
        halted_d = halted_q;
        hstat_d  = hstat_q;
        wr_en    = !halted_q && ((w_stat_q == SAOK) || (w_stat_q == SHLT));
        if (wr_en) begin
            if (32'(w_dste_q) < NREG) regs_d[w_dste_q[IDX_W-1:0]] = w_vale_q;
            if (32'(w_dstm_q) < NREG) regs_d[w_dstm_q[IDX_W-1:0]] = w_valm_q;
        end
        if (!halted_q && ((w_stat_q == SHLT) || (w_stat_q == SADR) || (w_stat_q == SINS))) begin
            halted_d = 1'b1;
            hstat_d  = w_stat_q;
        end
        if (halted_d)               stat_d = hstat_d;
        else if (w_stat_d == SBUB)  stat_d = SAOK;
        else                        stat_d = w_stat_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_stat_q  <= SBUB;
            w_icode_q <= INOP;
            w_dste_q  <= RNONE;
            w_vale_q  <= '0;
            w_dstm_q  <= RNONE;
            w_valm_q  <= '0;
            halted_q  <= 1'b0;
            hstat_q   <= SAOK;
            stat_q    <= SAOK;
            for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
        end else begin
            w_stat_q  <= w_stat_d;
            w_icode_q <= w_icode_d;
            w_dste_q  <= w_dste_d;
            w_vale_q  <= w_vale_d;
            w_dstm_q  <= w_dstm_d;
            w_valm_q  <= w_valm_d;
            halted_q  <= halted_d;
            hstat_q   <= hstat_d;
            stat_q    <= stat_d;
            for (int i = 0; i < int'(NREG); i++) regs_q[i] <= regs_d[i];
        end
    end

    // Reads show pre-edge contents; unimplemented ids and RNONE read as zero
    assign d_rvalA_o = (32'(d_srcA_i) < NREG) ? regs_q[d_srcA_i[IDX_W-1:0]] : '0;
    assign d_rvalB_o = (32'(d_srcB_i) < NREG) ? regs_q[d_srcB_i[IDX_W-1:0]] : '0;

    assign W_stat_o  = w_stat_q;
    assign W_icode_o = w_icode_q;
    assign W_dstE_o  = w_dste_q;
    assign W_valE_o  = w_vale_q;
    assign W_dstM_o  = w_dstm_q;
    assign W_valM_o  = w_valm_q;
    assign stat_o    = stat_q;
    assign halted_o  = halted_q;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Bench for wb_stage_regfile: directed scenarios plus randomized traffic
// compared against an architectural model of the W register and register file.
module tb_wb_stage_regfile;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned NREG   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              W_stall_i, W_bubble_i;
    logic [3:0]        M_stat_i, M_icode_i, M_dstE_i, M_dstM_i;
    logic [WORD_W-1:0] M_valE_i, m_valM_i;
    logic [3:0]        d_srcA_i, d_srcB_i;
    logic [3:0]        W_stat_o, W_icode_o, W_dstE_o, W_dstM_o, stat_o;
    logic [WORD_W-1:0] W_valE_o, W_valM_o, d_rvalA_o, d_rvalB_o;
    logic              halted_o;

    int n_checks = 0;
    int n_fail   = 0;

    wb_stage_regfile #(.WORD_W(WORD_W), .NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .W_stall_i(W_stall_i), .W_bubble_i(W_bubble_i),
        .M_stat_i(M_stat_i), .M_icode_i(M_icode_i),
        .M_dstE_i(M_dstE_i), .M_valE_i(M_valE_i),
        .M_dstM_i(M_dstM_i), .m_valM_i(m_valM_i),
        .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
        .W_stat_o(W_stat_o), .W_icode_o(W_icode_o),
        .W_dstE_o(W_dstE_o), .W_valE_o(W_valE_o),
        .W_dstM_o(W_dstM_o), .W_valM_o(W_valM_o),
        .d_rvalA_o(d_rvalA_o), .d_rvalB_o(d_rvalB_o),
        .stat_o(stat_o), .halted_o(halted_o)
    );

    always #5 clk = ~clk;

    task automatic set_m_idle();
        W_stall_i = 1'b0; W_bubble_i = 1'b0;
        M_stat_i = 4'd0; M_icode_i = 4'd1;
        M_dstE_i = 4'hF; M_valE_i = '0;
        M_dstM_i = 4'hF; m_valM_i = '0;
    endtask

    task automatic set_m(input logic [3:0] st, input logic [3:0] de, input logic [31:0] ve,
                         input logic [3:0] dm, input logic [31:0] vm);
        M_stat_i = st; M_icode_i = 4'd6;
        M_dstE_i = de; M_valE_i = ve;
        M_dstM_i = dm; m_valM_i = vm;
    endtask

    task automatic do_reset();
        set_m_idle();
        d_srcA_i = 4'hF; d_srcB_i = 4'hF;
        #2 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (W_dstE_o !== 4'hF || W_dstM_o !== 4'hF || W_stat_o !== 4'd0 || W_icode_o !== 4'd1) begin
            n_fail++;
            $display("FAIL reset_w: stat=%0h icode=%0h dstE=%0h dstM=%0h, want 0 1 f f",
                     W_stat_o, W_icode_o, W_dstE_o, W_dstM_o);
        end
        n_checks++;
        if (stat_o !== 4'd1 || halted_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stat: stat_o=%0h halted=%0b, want 1 0", stat_o, halted_o);
        end
        for (int i = 0; i < 16; i++) begin
            d_srcA_i = 4'(i); d_srcB_i = 4'(15 - i);
            #1;
            n_checks++;
            if (d_rvalA_o !== '0 || d_rvalB_o !== '0) begin
                n_fail++;
                $display("FAIL reset_read id=%0d: A=%h B=%h, want 0", i, d_rvalA_o, d_rvalB_o);
            end
        end
    endtask

    task automatic test_basic_write();
        do_reset();
        set_m(4'd1, 4'd0, 32'h12345678, 4'hF, 32'h0);
        @(posedge clk); #1;
        n_checks++;
        if (W_valE_o !== 32'h12345678 || W_dstE_o !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_w: valE=%h dstE=%0h, want 12345678 0", W_valE_o, W_dstE_o);
        end
        d_srcA_i = 4'd0; #1;
        n_checks++;
        if (d_rvalA_o !== 32'h0) begin
            n_fail++;
            $display("FAIL basic_old_read: got %h want 0", d_rvalA_o);
        end
        set_m_idle();
        @(posedge clk); #1;
        n_checks++;
        if (d_rvalA_o !== 32'h12345678) begin
            n_fail++;
            $display("FAIL basic_new_read: got %h want 12345678", d_rvalA_o);
        end
    endtask

    task automatic test_popl_esp();
        do_reset();
        set_m(4'd1, 4'd4, 32'h100, 4'd4, 32'hBEEF);
        @(posedge clk); #1;
        set_m_idle();
        @(posedge clk); #1;
        d_srcA_i = 4'd4; #1;
        n_checks++;
        if (d_rvalA_o !== 32'hBEEF) begin
            n_fail++;
            $display("FAIL popl_esp: reg4=%h want 0000beef", d_rvalA_o);
        end
    endtask

    task automatic test_stall_bubble();
        do_reset();
        set_m(4'd1, 4'd5, 32'hA5A5, 4'hF, 32'h0);
        @(posedge clk); #1;
        W_stall_i = 1'b1;
        d_srcB_i = 4'd5;
        for (int c = 0; c < 3; c++) begin
            set_m(4'd1, 4'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 7)), $urandom);
            @(posedge clk); #1;
            n_checks++;
            if (W_stat_o !== 4'd1 || W_dstE_o !== 4'd5 || W_valE_o !== 32'hA5A5 || W_dstM_o !== 4'hF) begin
                n_fail++;
                $display("FAIL stall_hold c=%0d: stat=%0h dstE=%0h valE=%h dstM=%0h, want 1 5 a5a5 f",
                         c, W_stat_o, W_dstE_o, W_valE_o, W_dstM_o);
            end
            n_checks++;
            if (d_rvalB_o !== 32'hA5A5) begin
                n_fail++;
                $display("FAIL stall_rewrite c=%0d: reg5=%h want a5a5", c, d_rvalB_o);
            end
        end
        W_bubble_i = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (W_stat_o !== 4'd0 || W_dstE_o !== 4'hF || W_dstM_o !== 4'hF || stat_o !== 4'd1) begin
            n_fail++;
            $display("FAIL stall_bubble: W_stat=%0h dstE=%0h dstM=%0h stat_o=%0h, want 0 f f 1",
                     W_stat_o, W_dstE_o, W_dstM_o, stat_o);
        end
        set_m_idle();
    endtask

    task automatic test_exception();
        do_reset();
        set_m(4'd3, 4'd2, 32'hDEAD, 4'hF, 32'h0);
        @(posedge clk); #1;
        set_m_idle();
        @(posedge clk); #1;
        d_srcA_i = 4'd2; #1;
        n_checks++;
        if (d_rvalA_o !== 32'h0 || stat_o !== 4'd3 || halted_o !== 1'b1) begin
            n_fail++;
            $display("FAIL exc_retire: reg2=%h stat_o=%0h halted=%0b, want 0 3 1",
                     d_rvalA_o, stat_o, halted_o);
        end
        set_m(4'd1, 4'd1, 32'h55, 4'hF, 32'h0);
        @(posedge clk); #1;
        set_m_idle();
        @(posedge clk); #1;
        d_srcA_i = 4'd1; #1;
        n_checks++;
        if (d_rvalA_o !== 32'h0 || stat_o !== 4'd3 || halted_o !== 1'b1) begin
            n_fail++;
            $display("FAIL exc_frozen: reg1=%h stat_o=%0h halted=%0b, want 0 3 1",
                     d_rvalA_o, stat_o, halted_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_m(4'd1, 4'd3, 32'h7, 4'hF, 32'h0);
        @(posedge clk); #1;
        set_m_idle();
        n_checks++;
        if (W_dstE_o !== 4'd3 || W_valE_o !== 32'h7) begin
            n_fail++;
            $display("FAIL midrst_load: dstE=%0h valE=%h, want 3 7", W_dstE_o, W_valE_o);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (W_dstE_o !== 4'hF || W_valE_o !== '0 || W_stat_o !== 4'd0 || stat_o !== 4'd1 || halted_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: dstE=%0h valE=%h stat=%0h stat_o=%0h halted=%0b, want f 0 0 1 0",
                     W_dstE_o, W_valE_o, W_stat_o, stat_o, halted_o);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        d_srcA_i = 4'd3; #1;
        n_checks++;
        if (d_rvalA_o !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_reg3: got %h want 0", d_rvalA_o);
        end
    endtask

    // Architectural model: W contents, register array and halt state advanced once per edge
    task automatic test_random();
        logic [31:0] mregs [NREG];
        logic [3:0]  ws, wi, wde, wdm, hs;
        logic [31:0] wve, wvm;
        logic        mh;
        logic [3:0]  exp_stat;
        logic [31:0] exp_a, exp_b;
        int          r;
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            for (int i = 0; i < int'(NREG); i++) mregs[i] = 0;
            ws = 0; wi = 1; wde = 4'hF; wdm = 4'hF; wve = 0; wvm = 0; mh = 0; hs = 1;
            for (int c = 0; c < 80; c++) begin
                r = int'($urandom_range(0, 99));
                M_stat_i  = (r < 3) ? 4'($urandom_range(2, 4)) : (r < 10) ? 4'd0 : 4'd1;
                M_icode_i = 4'($urandom);
                M_dstE_i  = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
                M_dstM_i  = ($urandom_range(0, 9) < 4) ? 4'($urandom_range(0, 7)) : 4'hF;
                M_valE_i  = $urandom;
                m_valM_i  = $urandom;
                W_stall_i  = ($urandom_range(0, 9) == 0);
                W_bubble_i = ($urandom_range(0, 14) == 0);
                @(posedge clk);
                if (!mh && (ws == 1 || ws == 2)) begin
                    if (wde < NREG) mregs[wde] = wve;
                    if (wdm < NREG) mregs[wdm] = wvm;
                end
                if (!mh && ws >= 2 && ws <= 4) begin
                    mh = 1; hs = ws;
                end
                if (W_bubble_i) begin
                    ws = 0; wi = 1; wde = 4'hF; wdm = 4'hF; wve = 0; wvm = 0;
                end else if (!W_stall_i) begin
                    ws = M_stat_i; wi = M_icode_i; wde = M_dstE_i; wve = M_valE_i;
                    wdm = M_dstM_i; wvm = m_valM_i;
                end
                #1;
                d_srcA_i = 4'($urandom);
                d_srcB_i = 4'($urandom_range(0, 7));
                #1;
                exp_stat = mh ? hs : (ws == 0 ? 4'd1 : ws);
                exp_a = (d_srcA_i < NREG) ? mregs[d_srcA_i] : 32'h0;
                exp_b = (d_srcB_i < NREG) ? mregs[d_srcB_i] : 32'h0;
                n_checks++;
                if (W_stat_o !== ws || W_icode_o !== wi || W_dstE_o !== wde || W_valE_o !== wve ||
                    W_dstM_o !== wdm || W_valM_o !== wvm) begin
                    n_fail++;
                    $display("FAIL rand_w ep=%0d c=%0d: got %0h %0h %0h %h %0h %h want %0h %0h %0h %h %0h %h",
                             ep, c, W_stat_o, W_icode_o, W_dstE_o, W_valE_o, W_dstM_o, W_valM_o,
                             ws, wi, wde, wve, wdm, wvm);
                end
                n_checks++;
                if (stat_o !== exp_stat || halted_o !== mh) begin
                    n_fail++;
                    $display("FAIL rand_stat ep=%0d c=%0d: stat_o=%0h halted=%0b want %0h %0b",
                             ep, c, stat_o, halted_o, exp_stat, mh);
                end
                n_checks++;
                if (d_rvalA_o !== exp_a || d_rvalB_o !== exp_b) begin
                    n_fail++;
                    $display("FAIL rand_read ep=%0d c=%0d: A[%0d]=%h B[%0d]=%h want %h %h",
                             ep, c, d_srcA_i, d_rvalA_o, d_srcB_i, d_rvalB_o, exp_a, exp_b);
                end
            end
        end
        set_m_idle();
    endtask

    initial begin
        set_m_idle();
        d_srcA_i = 4'hF; d_srcB_i = 4'hF;
        test_reset();
        test_basic_write();
        test_popl_esp();
        test_stall_bubble();
        test_exception();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
